// File: rtl/line_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : line_sequencer
// Description : Queues polyline points and feeds consecutive point pairs to a
//               line drawer as {x0,y0}->{x1,y1} segments with a one-cycle go
//               pulse, then waits for the drawer's done handshake.
// Config      : CLOSE_LOOP_EN (macro) - adds the close_req port; a close entry
//               draws a segment from the last point back to the polyline's
//               first point. Undefined: no close_req, close flag tied to 0.
// Ports       : CLOCK_50        clock, rising edge
//               resetN          asynchronous active-low reset
//               pt_x/pt_y       point coordinates (0..319 / 0..239)
//               pt_new          point starts a new polyline (draws nothing)
//               pt_valid        push request; transfer when pt_ready is high
//               pt_ready        FIFO not full
//               close_req       push close entry (CLOSE_LOOP_EN only)
//               x0,y0,x1,y1     segment endpoints, stable from go to release
//               go              one-cycle segment start pulse
//               done            drawer completion, high >= 1 cycle
//               busy            FIFO non-empty or sequencer active
//               fifo_count      FIFO occupancy
//               lines_issued    go pulses since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module line_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        resetN,
  input  logic [8:0]                  pt_x,
  input  logic [7:0]                  pt_y,
  input  logic                        pt_new,
  input  logic                        pt_valid,
  output logic                        pt_ready,
`ifdef CLOSE_LOOP_EN
  input  logic                        close_req,
`endif
  output logic [8:0]                  x0,
  output logic [7:0]                  y0,
  output logic [8:0]                  x1,
  output logic [7:0]                  y1,
  output logic                        go,
  input  logic                        done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  lines_issued
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 19;  // {close, new, x[8:0], y[7:0]}

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_GO        = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_REL  = 3'd4
  } state_t;

  state_t state, state_next;

  // --------------------------------------------------------------------------
  // Point FIFO
  // --------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push_req, push, pop;
  logic [EW-1:0] entry_in, head;

`ifdef CLOSE_LOOP_EN
  // close_req wins over a point presented on the same edge; the point is dropped
  assign push_req = close_req | pt_valid;
  assign entry_in = close_req ? {1'b1, 1'b0, 9'd0, 8'd0}
                              : {1'b0, pt_new, pt_x, pt_y};
`else
  assign push_req = pt_valid;
  assign entry_in = {1'b0, pt_new, pt_x, pt_y};
`endif

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // full gates the push even if a pop frees a slot on the same edge
  assign push  = push_req & ~full;
  assign pop   = (state == S_POP) & ~empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic       head_close, head_new;
  logic [8:0] head_x;
  logic [7:0] head_y;
  assign {head_close, head_new, head_x, head_y} = head;

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  logic       has_prev;
  logic [8:0] prev_x;
  logic [7:0] prev_y;
`ifdef CLOSE_LOOP_EN
  logic [8:0] first_x;
  logic [7:0] first_y;
`endif

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!empty) state_next = S_POP;
      end
      S_POP: begin
        if (head_close) begin
`ifdef CLOSE_LOOP_EN
          state_next = has_prev ? S_GO : S_IDLE;
`else
          state_next = S_IDLE;
`endif
        end else if (!has_prev || head_new) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_GO;
        end
      end
      S_GO:        state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (done)  state_next = S_WAIT_REL;
      // wait for done to drop so the drawer is re-armed before the next go
      S_WAIT_REL:  if (!done) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Endpoint / polyline tracking; endpoints only move in POP
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      has_prev     <= 1'b0;
      prev_x       <= '0;
      prev_y       <= '0;
`ifdef CLOSE_LOOP_EN
      first_x      <= '0;
      first_y      <= '0;
`endif
      x0           <= '0;
      y0           <= '0;
      x1           <= '0;
      y1           <= '0;
      lines_issued <= '0;
    end else begin
      if (state == S_GO) lines_issued <= lines_issued + 8'd1;
      if (pop) begin
        if (head_close) begin
`ifdef CLOSE_LOOP_EN
          if (has_prev) begin
            x0       <= prev_x;
            y0       <= prev_y;
            x1       <= first_x;
            y1       <= first_y;
            has_prev <= 1'b0;
          end
`endif
        end else if (!has_prev || head_new) begin
          // anchor point of a new polyline
          prev_x   <= head_x;
          prev_y   <= head_y;
`ifdef CLOSE_LOOP_EN
          first_x  <= head_x;
          first_y  <= head_y;
`endif
          has_prev <= 1'b1;
        end else begin
          x0     <= prev_x;
          y0     <= prev_y;
          x1     <= head_x;
          y1     <= head_y;
          prev_x <= head_x;
          prev_y <= head_y;
        end
      end
    end
  end

  assign go         = (state == S_GO);
  assign pt_ready   = ~full;
  assign busy       = ~empty | (state != S_IDLE);
  assign fifo_count = count;

endmodule
`default_nettype wire
